// File: rtl/spectrum_bar_renderer_pkg.sv
// spectrum_pkg: shared constants, colour palette, zone boundaries, FSM
// state type and the magnitude-to-bar-height scaling helper for the
// spectrum bar renderer.
package spectrum_pkg;

    localparam int H_PIXELS     = 640;
    localparam int V_PIXELS     = 480;
    localparam int DS_WIDTH     = 32;
    localparam int DS_HEIGHT    = 24;
    localparam int ADDR_WIDTH   = 10;
    localparam int MAG_WIDTH    = 8;
    localparam int DECAY_FRAMES = 4;

    localparam int COL_W = 5;
    localparam int ROW_W = 5;
    localparam int HGT_W = 5;
    localparam int IDX_W = 6;

    typedef logic [MAG_WIDTH-1:0] mag_t;
    typedef logic [HGT_W-1:0]     hgt_t;
    typedef logic [MAG_WIDTH+4:0] prod_t;

    localparam logic [7:0] COL_RED    = 8'hE0;
    localparam logic [7:0] COL_YELLOW = 8'hFC;
    localparam logic [7:0] COL_GREEN  = 8'h1C;
    localparam logic [7:0] COL_BG     = 8'h00;
    localparam logic [7:0] COL_PEAK   = 8'hFF;

    // Rows above ROW_RED_END are red, above ROW_YEL_END yellow, the rest green.
    localparam logic [ROW_W-1:0] ROW_RED_END = 5'd6;
    localparam logic [ROW_W-1:0] ROW_YEL_END = 5'd12;
    localparam logic [ROW_W-1:0] ROW_BASE    = ROW_W'(DS_HEIGHT);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(DS_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(DS_WIDTH - 1);
    localparam logic [9:0]       TRIG_LINE   = 10'(V_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_SWEEP  = 2'd2
    } state_e;

    // Ceiling-scaled height: 0 stays 0, any non-zero magnitude lights at
    // least one row, full scale lights all DS_HEIGHT rows.
    function automatic hgt_t mag_to_height(input mag_t mag);
        prod_t prod;
        prod = (prod_t'(mag) * prod_t'(DS_HEIGHT)) + prod_t'((1 << MAG_WIDTH) - 1);
        return hgt_t'(prod >> MAG_WIDTH);
    endfunction

endpackage

// File: rtl/spectrum_bar_renderer_if.sv
// spectrum_bar_renderer_if: bin input stream and frame-RAM write port of
// the spectrum bar renderer. The renderer uses the slave view, the bin
// producer / RAM side uses the master view.
interface spectrum_bar_renderer_if;
    import spectrum_pkg::*;

    logic [MAG_WIDTH-1:0]  bin_data;
    logic                  bin_valid;
    logic                  bin_last;
    logic                  bin_ready;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [7:0]            write_data;
    logic                  write_en;

    modport slave (
        input  bin_data, bin_valid, bin_last,
        output bin_ready, write_addr, write_data, write_en
    );

    modport master (
        output bin_data, bin_valid, bin_last,
        input  bin_ready, write_addr, write_data, write_en
    );

endinterface

// File: rtl/spectrum_bar_renderer_capture.sv
// spectrum_bin_capture: collects one set of bin magnitudes into a shadow
// bank. Bins beyond DS_WIDTH are accepted and discarded; a short set leaves
// the untouched entries at their previous values. After bin_last the input
// stalls (pending) until the renderer's commit beat consumes the set.
module spectrum_bin_capture
    import spectrum_pkg::*;
(
    input  logic  vgaclk,
    input  logic  rst,
    input  mag_t  bin_data,
    input  logic  bin_valid,
    input  logic  bin_last,
    output logic  bin_ready,
    input  logic  commit,
    output logic  load,
    output mag_t  shadow [DS_WIDTH]
);

    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DS_WIDTH);

    logic [IDX_W-1:0] index_q, index_d;
    logic             pending_q, pending_d;
    logic             accept;
    logic             in_range;

    assign bin_ready = !pending_q && rst;
    assign accept    = bin_valid && bin_ready;
    assign in_range  = (index_q < IDX_FULL);
    assign load      = commit && pending_q;

    // Index saturates at DS_WIDTH so an over-long set cannot wrap onto bin 0.
    always_comb begin
        index_d   = index_q;
        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            if (bin_last) begin
                index_d   = '0;
                pending_d = 1'b1;
            end else if (in_range) begin
                index_d = index_q + 1'b1;
            end
        end
    end

    // Index, pending flag and shadow bank registers.
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            index_q   <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < DS_WIDTH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            index_q   <= index_d;
            pending_q <= pending_d;
            if (accept && in_range) begin
                shadow[index_q[COL_W-1:0]] <= bin_data;
            end
        end
    end

endmodule

// File: rtl/spectrum_bar_renderer.sv
// spectrum_bar_renderer: converts captured spectrum bins into bar heights
// and, once per video frame at the start of vertical blanking, writes all
// DS_WIDTH x DS_HEIGHT blocks of the frame RAM in 3:3:2 colour.
// Optional feature macro: SPECTRUM_PEAK_HOLD_EN (slowly falling peak marker
// per column, drawn white above the bar).
//
// state  | meaning
// IDLE   | wait for hc==0 && vc==V_PIXELS
// COMMIT | load scaled shadow into active heights when a set is pending
// SWEEP  | one block write per cycle, row-major, address 0..767
module spectrum_bar_renderer
    import spectrum_pkg::*;
(
    input  logic                   vgaclk,
    input  logic                   rst,
    input  logic [9:0]             hc,
    input  logic [9:0]             vc,
    spectrum_bar_renderer_if.slave bus,
    output logic                   busy
);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q;
    logic                  trigger;
    logic                  commit;
    logic                  load;
    mag_t                  shadow [DS_WIDTH];
    hgt_t                  heights_q [DS_WIDTH];
    hgt_t                  h_cur;
    logic [7:0]            block_colour;

    spectrum_bin_capture u_capture (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .bin_data  (bus.bin_data),
        .bin_valid (bus.bin_valid),
        .bin_last  (bus.bin_last),
        .bin_ready (bus.bin_ready),
        .commit    (commit),
        .load      (load),
        .shadow    (shadow)
    );

    assign trigger        = (hc == 10'd0) && (vc == TRIG_LINE);
    assign bus.write_addr = wr_addr_q;
    assign bus.write_data = wr_data_q;
    assign bus.write_en   = wr_en_q;
    assign busy           = busy_q;

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam int FRM_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(DECAY_FRAMES - 1);

    hgt_t             peak_q [DS_WIDTH];
    hgt_t             peak_d [DS_WIDTH];
    hgt_t             h_new  [DS_WIDTH];
    logic [FRM_W-1:0] frame_q, frame_d;

    // Peak follows new maxima at once and falls one row per DECAY_FRAMES
    // frames, never below the current bar.
    always_comb begin
        hgt_t pk;
        pk      = '0;
        frame_d = frame_q;
        for (int i = 0; i < DS_WIDTH; i++) begin
            h_new[i]  = load ? mag_to_height(shadow[i]) : heights_q[i];
            peak_d[i] = peak_q[i];
        end
        if (commit) begin
            frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + 1'b1;
            for (int i = 0; i < DS_WIDTH; i++) begin
                pk = (h_new[i] > peak_q[i]) ? h_new[i] : peak_q[i];
                if ((frame_q == FRM_LAST) && (pk != '0) && (pk > h_new[i])) begin
                    pk = pk - 1'b1;
                end
                peak_d[i] = pk;
            end
        end
    end

    // Peak and frame-counter registers.
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            frame_q <= '0;
            for (int i = 0; i < DS_WIDTH; i++) begin
                peak_q[i] <= '0;
            end
        end else begin
            frame_q <= frame_d;
            for (int i = 0; i < DS_WIDTH; i++) begin
                peak_q[i] <= peak_d[i];
            end
        end
    end
`endif

    // Colour of the block addressed by the sweep counters.
    always_comb begin
        h_cur        = heights_q[col_q];
        block_colour = COL_BG;
        if (row_q >= (ROW_BASE - h_cur)) begin
            if (row_q < ROW_RED_END) begin
                block_colour = COL_RED;
            end else if (row_q < ROW_YEL_END) begin
                block_colour = COL_YELLOW;
            end else begin
                block_colour = COL_GREEN;
            end
        end
`ifdef SPECTRUM_PEAK_HOLD_EN
        if ((peak_q[col_q] != '0) && (row_q == (ROW_BASE - peak_q[col_q]))) begin
            block_colour = COL_PEAK;
        end
`endif
    end

    // Sequencer next state and next write-port values.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        commit    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                wr_en_d   = 1'b1;
                // DS_WIDTH is a power of two, so row*DS_WIDTH+col is a concatenation.
                wr_addr_d = {row_q, col_q};
                wr_data_d = block_colour;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, sweep counters and registered outputs.
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= (state_d != ST_IDLE) || wr_en_d;
        end
    end

    // Active height bank; the sweep only ever reads this copy.
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            for (int i = 0; i < DS_WIDTH; i++) begin
                heights_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < DS_WIDTH; i++) begin
                heights_q[i] <= mag_to_height(shadow[i]);
            end
        end
    end

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Testbench for spectrum_bar_renderer: random bin sets, a frame-level
// reference model and a write scoreboard checked by a separate monitor.
module tb_spectrum_bar_renderer;
    import spectrum_pkg::*;

    logic       vgaclk = 1'b0;
    logic       rst;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       busy;

    spectrum_bar_renderer_if bus ();

    spectrum_bar_renderer dut (
        .vgaclk (vgaclk),
        .rst    (rst),
        .hc     (hc),
        .vc     (vc),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 vgaclk = ~vgaclk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  mags[64];

    // reference model state
    int  m_shadow[DS_WIDTH];
    int  m_active[DS_WIDTH];
    int  m_peak[DS_WIDTH];
    int  m_frame   = 0;
    int  m_index   = 0;
    bit  m_pending = 0;
    bit  m_sweep_valid = 0;
    int  m_k = 0;

    always @(posedge vgaclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int height_of(input int mag);
        return (mag * DS_HEIGHT + 255) / 256;
    endfunction

    function automatic int expected_colour(input int r, input int c);
        int h;
        int col;
        h   = m_active[c];
        col = 8'h00;
        if (r >= DS_HEIGHT - h) begin
            if (r < 6)       col = 8'hE0;
            else if (r < 12) col = 8'hFC;
            else             col = 8'h1C;
        end
`ifdef SPECTRUM_PEAK_HOLD_EN
        if (m_peak[c] > 0 && r == DS_HEIGHT - m_peak[c]) col = 8'hFF;
`endif
        return col;
    endfunction

    // Commit beat: latch pending set, update peaks, queue the frame's writes.
    task automatic model_commit(input int e);
        wr_t w;
        if (m_pending) begin
            for (int c = 0; c < DS_WIDTH; c++) m_active[c] = height_of(m_shadow[c]);
            m_pending = 0;
        end
`ifdef SPECTRUM_PEAK_HOLD_EN
        begin
            bit wrap;
            int pk;
            wrap    = (m_frame == DECAY_FRAMES - 1);
            m_frame = wrap ? 0 : m_frame + 1;
            for (int c = 0; c < DS_WIDTH; c++) begin
                pk = (m_active[c] > m_peak[c]) ? m_active[c] : m_peak[c];
                if (wrap && pk > 0 && pk > m_active[c]) pk--;
                m_peak[c] = pk;
            end
        end
`endif
        for (int r = 0; r < DS_HEIGHT; r++) begin
            for (int c = 0; c < DS_WIDTH; c++) begin
                w.addr = r * DS_WIDTH + c;
                w.data = expected_colour(r, c);
                w.cyc  = e + 1 + w.addr;
                exp_q.push_back(w);
            end
        end
    endtask

    // Model: check ready/busy for the last edge, then predict the next edge.
    always @(negedge vgaclk) begin
        int  e;
        bit  rdy;
        wr_t keep[$];
        e   = cyc + 1;
        rdy = !m_pending;
        if (cyc > 0) begin
            check("bin_ready", bus.bin_ready, rst && !m_pending);
            check("busy", busy, m_sweep_valid && cyc >= m_k && cyc <= m_k + 769);
        end
        if (!rst) begin
            for (int c = 0; c < DS_WIDTH; c++) begin
                m_shadow[c] = 0;
                m_active[c] = 0;
                m_peak[c]   = 0;
            end
            m_frame = 0;
            m_index = 0;
            m_pending = 0;
            m_sweep_valid = 0;
            keep.delete();
            foreach (exp_q[i]) if (exp_q[i].cyc < e) keep.push_back(exp_q[i]);
            exp_q = keep;
        end else begin
            if (m_sweep_valid && e == m_k + 1) model_commit(e);
            if (hc == 10'd0 && vc == 10'(V_PIXELS) && (!m_sweep_valid || e >= m_k + 770)) begin
                m_sweep_valid = 1;
                m_k = e;
            end
            if (bus.bin_valid && rdy) begin
                if (m_index < DS_WIDTH) m_shadow[m_index] = int'(bus.bin_data);
                if (bus.bin_last) begin
                    m_index   = 0;
                    m_pending = 1;
                end else begin
                    m_index++;
                end
            end
        end
    end

    // Monitor: compare every cycle's write port against the scoreboard.
    always @(negedge vgaclk) begin
        wr_t w;
        if (cyc > 0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                w = exp_q.pop_front();
                check("write_en", bus.write_en, 1'b1);
                check("write_addr", bus.write_addr, w.addr);
                check("write_data", bus.write_data, w.data);
            end else begin
                check("write_en_idle", bus.write_en, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic trigger();
        hc = 10'd0;
        vc = 10'(V_PIXELS);
        tick();
        hc = 10'd5;
        vc = 10'd0;
    endtask

    task automatic send_bin(input int data, input bit last);
        bit acc;
        int g;
        acc = 0;
        g   = 0;
        bus.bin_valid = 1'b1;
        bus.bin_data  = 8'(data);
        bus.bin_last  = last;
        while (!acc && g < 4000) begin
            acc = bus.bin_ready;
            tick();
            g++;
        end
        bus.bin_valid = 1'b0;
        bus.bin_last  = 1'b0;
        check("handshake_timeout", acc, 1'b1);
    endtask

    task automatic send_set(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            send_bin(mags[i], i == n - 1);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() > 0 || busy) && g < 3000) begin
            tick();
            g++;
        end
        check("sweep_timeout", (g < 3000), 1'b1);
        repeat (3) tick();
    endtask

    task automatic random_mags(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(3, 0))
                0:       mags[i] = 0;
                1:       mags[i] = $urandom_range(10, 1);
                2:       mags[i] = $urandom_range(255, 245);
                default: mags[i] = $urandom_range(255, 0);
            endcase
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hit;
        rst = 1'b0;
        hc  = 10'd5;
        vc  = 10'd0;
        bus.bin_valid = 1'b0;
        bus.bin_data  = '0;
        bus.bin_last  = 1'b0;
        repeat (3) tick();
        check("rst_write_en", bus.write_en, 1'b0);
        check("rst_write_addr", bus.write_addr, 0);
        check("rst_write_data", bus.write_data, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_bin_ready", bus.bin_ready, 1'b0);
        rst = 1'b1;
        tick();

        // full-scale bars: colour zones only
        for (int i = 0; i < 32; i++) mags[i] = 255;
        send_set(32, 0);
        trigger();
        wait_idle();

        // single lowest block
        for (int i = 0; i < 32; i++) mags[i] = 0;
        mags[0] = 1;
        send_set(32, 0);
        trigger();
        wait_idle();

        // second set held off while first is pending, lands during the sweep
        random_mags(32);
        send_set(32, 0);
        random_mags(32);
        fork
            send_set(32, 1);
            begin
                repeat (20) tick();
                trigger();
            end
        join
        wait_idle();
        trigger();
        wait_idle();

        // over-long set: bins 32..39 dropped
        random_mags(40);
        send_set(40, 0);
        trigger();
        wait_idle();

        // short set keeps untouched entries; then a frame with nothing pending
        random_mags(10);
        send_set(10, 2);
        trigger();
        wait_idle();
        trigger();
        wait_idle();

        // bin_last accepted on the commit beat: shown one frame later
        random_mags(32);
        for (int i = 0; i < 31; i++) send_bin(mags[i], 1'b0);
        trigger();
        send_bin(mags[31], 1'b1);
        wait_idle();
        trigger();
        wait_idle();

        // random rounds
        for (int k = 0; k < 3; k++) begin
            random_mags(40);
            send_set($urandom_range(40, 5), 3);
            trigger();
            wait_idle();
        end

        // reset while sweep is at address 100, then an all-background frame
        trigger();
        hit = 0;
        for (int g = 0; g < 400 && !hit; g++) begin
            tick();
            if (bus.write_en === 1'b1 && bus.write_addr == 10'd100) hit = 1;
        end
        check("reached_addr_100", hit, 1);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        trigger();
        wait_idle();

        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_renderer.md
# spectrum_bar_renderer

Upstream producer for the ping-pong frame RAM in the VGA path: accepts one frame of audio spectrum magnitudes over a valid/ready stream, converts each of 32 bins into a bar height on the 32x24 block grid and, once per video frame during vertical blanking, sweeps all 768 block addresses, emitting write_addr/write_data/write_en in 3:3:2 colour. It replaces the free-running graphics generator and is timed off the VGA counters hc/vc.

## Interface
- H_PIXELS, 640, active horizontal pixels
- V_PIXELS, 480, active vertical pixels; sweep trigger line
- DS_WIDTH, 32, grid columns = number of bins
- DS_HEIGHT, 24, grid rows
- ADDR_WIDTH, 10, write address width ($clog2(DS_WIDTH*DS_HEIGHT))
- MAG_WIDTH, 8, bin magnitude width
- DECAY_FRAMES, 4, frames per one-row peak decay (PEAK_HOLD_EN only)

- vgaclk  in  1  pixel clock (25 MHz); all logic on posedge
- rst  in  1  reset, synchronous, active-low
- hc  in  10  VGA horizontal counter
- vc  in  10  VGA vertical counter
- bin_data  in  MAG_WIDTH  bin magnitude, bin 0 first
- bin_valid  in  1  bin_data valid
- bin_last  in  1  marks final bin of a set
- bin_ready  out  1  bin accepted when bin_valid && bin_ready
- write_addr  out  ADDR_WIDTH  block address, row*DS_WIDTH+col
- write_data  out  8  pixel colour, R[7:5] G[4:2] B[1:0]
- write_en  out  1  write strobe
- busy  out  1  high while sweep in progress

## Operation
- Capture: shadow bank of DS_WIDTH magnitudes; index counter from 0, increments per accepted bin. Index >= DS_WIDTH: bin accepted, dropped. Accepted bin_last: index -> 0, pending set. Set ends early: unwritten shadow entries keep previous values.
- bin_ready = !pending && rst. Pending cleared in COMMIT.
- Height: h = (mag*DS_HEIGHT + 2^MAG_WIDTH - 1) >> MAG_WIDTH, range 0..24 (0->0, 1->1, 255->24). Intermediate width MAG_WIDTH+5, no truncation.
- FSM states IDLE, COMMIT, SWEEP.
  - IDLE -> COMMIT when hc==0 && vc==V_PIXELS.
  - COMMIT: if pending, active heights <= scaled shadow, pending <= 0; else active unchanged. Then -> SWEEP, row=col=0.
  - SWEEP: one write per cycle, col increments, wraps to 0 with row++; after addr 767 -> IDLE.
  - Trigger while COMMIT/SWEEP ignored.
- Block (row r, col c), r=0 top: lit iff r >= DS_HEIGHT - h[c]. Lit colour: r<6 8'hE0 (red), r<12 8'hFC (yellow), else 8'h1C (green). Unlit 8'h00.
- Bin stream may run concurrently with SWEEP; sweep reads active bank only, so no tearing.

## Timing
- Reset: write_en=0, write_addr=0, write_data=0, busy=0, bin_ready=0 while rst low, 1 on first cycle after release; heights, shadow, pending, index, peaks cleared; FSM IDLE.
- Outputs registered. Trigger sampled at edge k -> COMMIT after k+1 -> write_en high after edges k+2..k+769 (768 consecutive cycles, addr 0..767 in order); busy high same cycles plus COMMIT.
- Sweep completes well inside vertical blanking (45 lines x 800 clocks).
- Reset asserted mid-sweep: write_en low after next edge, no further writes; sweep not resumed.
- bin_last accepted in same cycle as COMMIT: pending set after COMMIT, consumed next frame.

## Configuration
- SPECTRUM_PEAK_HOLD_EN defined: per-column peak register 0..24. In COMMIT: peak <= max(peak, new h); frame counter wraps at DECAY_FRAMES, on wrap peak decrements if >0 and > h. Block at r == DS_HEIGHT - peak (peak>0) drawn 8'hFF, overriding bar colour.
- Undefined: no peak registers or frame counter; only bars drawn; DECAY_FRAMES unused.

## Structure
- Package spectrum_pkg: DS_WIDTH, DS_HEIGHT, colour constants (COL_RED, COL_YELLOW, COL_GREEN, COL_BG, COL_PEAK), zone row boundaries, FSM state enum.
- Sub-module spectrum_bin_capture: shadow bank, index counter, pending flag, bin_ready; exposes shadow array and commit strobe.

## Test plan
- Reset, then bins all 8'hFF with bin_last on bin 31, trigger -> 768 writes starting 2 cycles after trigger; rows 0-5 8'hE0, 6-11 8'hFC, 12-23 8'h1C.
- Bin 0 = 1, rest 0 -> only addr 736 (row 23, col 0) = 8'h1C; all else 8'h00.
- Second set sent before trigger -> bin_ready low after first bin_last until COMMIT; set accepted afterwards, displayed next frame.
- 40 bins, bin_last on 40th -> bins 32-39 dropped, display matches first 32.
- rst low at sweep address 100 -> write_en low next cycle; next trigger sweeps all-background.
- PEAK_HOLD_EN, DECAY_FRAMES=4: bin 0 = 255 then 0 -> addr 0 = 8'hFF; peak drops one row every 4 frames until 0.
